// File: rtl/dcache_assoc.sv
// dcache_assoc: set-associative write-back data cache with per-set LRU ages and halt-driven flush.
// Ports: CLK/nRST clock and async active-low reset; dmemREN/dmemWEN/dmemaddr/dmemstore datapath request;
// halt requests a flush of dirty blocks; dhit/dmemload answer the request; flushed is sticky once the
// flush finishes; dREN/dWEN/daddr/dstore/dload/dwait form the word-at-a-time memory port.
module dcache_assoc #(
  parameter int WAYS      = 2,
  parameter int SETS      = 8,
  parameter int BLK_WORDS = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  input  logic        halt,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic [31:0] dload,
  input  logic        dwait
);
  localparam int BO = $clog2(BLK_WORDS);
  localparam int IW = $clog2(SETS);
  localparam int TW = 30 - BO - IW;
  localparam int WW = WAYS > 1 ? $clog2(WAYS) : 1;
  localparam int BW = BLK_WORDS > 1 ? BO : 1;
  localparam int FW = $clog2(SETS * WAYS);

  typedef enum logic [2:0] {IDLE, WB, FETCH, FLUSH, DONE} state_t;

  state_t        r_state;
  logic [BW-1:0] r_word;
  logic [WW-1:0] r_way;
  logic [IW-1:0] r_idx;
  logic [TW-1:0] r_rtag;
  logic [FW-1:0] r_fcnt;
  logic          r_fl;
  logic          r_valid [WAYS][SETS];
  logic          r_dirty [WAYS][SETS];
  logic [WW-1:0] r_age   [SETS][WAYS];
  logic [TW-1:0] r_tag   [WAYS][SETS];
  logic [31:0]   r_data  [WAYS][SETS][BLK_WORDS];

  logic [BW-1:0] w_boff;
  logic [IW-1:0] w_idx;
  logic [TW-1:0] w_tag;
  logic          w_req;
  logic          w_hit;
  logic [WW-1:0] w_hway;
  logic [WW-1:0] w_vict;
  logic          w_xfer;
  logic          w_last;
  logic          w_flast;
  logic [WW-1:0] w_fway;
  logic [IW-1:0] w_fset;
  logic [31:0]   w_wbaddr;
  logic [31:0]   w_fetchaddr;

  assign w_boff = BW'((dmemaddr >> 2) % BLK_WORDS);
  assign w_idx  = IW'((dmemaddr >> (2 + BO)) % SETS);
  assign w_tag  = TW'(dmemaddr >> (2 + BO + IW));

  // Victim: the oldest way, overridden by the lowest-numbered invalid way when one exists.
  always_comb begin
    w_hit  = 1'b0;
    w_hway = '0;
    w_vict = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_valid[w][w_idx] && r_tag[w][w_idx] == w_tag) begin
        w_hit  = 1'b1;
        w_hway = WW'(w);
      end
      if (r_age[w_idx][w] == WW'(WAYS - 1)) w_vict = WW'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--)
      if (!r_valid[w][w_idx]) w_vict = WW'(w);
  end

  assign w_req       = (dmemREN || dmemWEN) && !halt && r_state == IDLE;
  assign dhit        = w_req && w_hit;
  assign dmemload    = (dhit && dmemREN) ? r_data[w_hway][w_idx][w_boff] : '0;
  assign w_xfer      = !dwait;
  assign w_last      = r_word == BW'(BLK_WORDS - 1);
  assign w_flast     = r_fcnt == FW'(SETS * WAYS - 1);
  assign w_fway      = WW'(r_fcnt % WAYS);
  assign w_fset      = IW'(r_fcnt / WAYS);
  assign w_wbaddr    = (32'(r_tag[r_way][r_idx]) << (2 + BO + IW)) | (32'(r_idx) << (2 + BO)) | (32'(r_word) << 2);
  assign w_fetchaddr = (32'(r_rtag) << (2 + BO + IW)) | (32'(r_idx) << (2 + BO)) | (32'(r_word) << 2);
  assign dREN        = r_state == FETCH;
  assign dWEN        = r_state == WB;
  assign flushed     = r_state == DONE;
  assign daddr       = dWEN ? w_wbaddr : dREN ? w_fetchaddr : '0;
  assign dstore      = dWEN ? r_data[r_way][r_idx][r_word] : '0;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_word  <= '0;
      r_way   <= '0;
      r_idx   <= '0;
      r_rtag  <= '0;
      r_fcnt  <= '0;
      r_fl    <= 1'b0;
      for (int w = 0; w < WAYS; w++)
        for (int s = 0; s < SETS; s++) begin
          r_valid[w][s] <= 1'b0;
          r_dirty[w][s] <= 1'b0;
          r_age[s][w]   <= WW'(w);
        end
    end else begin
      case (r_state)
        IDLE:
          if (halt) begin
            r_state <= FLUSH;
            r_fcnt  <= '0;
          end else if (w_req && w_hit) begin
            for (int w = 0; w < WAYS; w++)
              if (WW'(w) == w_hway) r_age[w_idx][w] <= '0;
              else if (r_age[w_idx][w] < r_age[w_idx][w_hway]) r_age[w_idx][w] <= r_age[w_idx][w] + 1'b1;
            if (dmemWEN) r_dirty[w_hway][w_idx] <= 1'b1;
          end else if (w_req) begin
            r_way   <= w_vict;
            r_idx   <= w_idx;
            r_rtag  <= w_tag;
            r_word  <= '0;
            r_fl    <= 1'b0;
            r_state <= (r_valid[w_vict][w_idx] && r_dirty[w_vict][w_idx]) ? WB : FETCH;
          end
        WB:
          if (w_xfer && !w_last) r_word <= r_word + 1'b1;
          else if (w_xfer) begin
            r_word <= '0;
            if (r_fl) begin
              r_dirty[r_way][r_idx] <= 1'b0;
              r_state <= w_flast ? DONE : FLUSH;
              if (!w_flast) r_fcnt <= r_fcnt + 1'b1;
            end else r_state <= FETCH;
          end
        FETCH:
          if (w_xfer && !w_last) r_word <= r_word + 1'b1;
          else if (w_xfer) begin
            r_word                <= '0;
            r_valid[r_way][r_idx] <= 1'b1;
            r_dirty[r_way][r_idx] <= 1'b0;
            r_state               <= IDLE;
          end
        FLUSH:
          if (r_valid[w_fway][w_fset] && r_dirty[w_fway][w_fset]) begin
            r_way   <= w_fway;
            r_idx   <= w_fset;
            r_word  <= '0;
            r_fl    <= 1'b1;
            r_state <= WB;
          end else if (w_flast) r_state <= DONE;
          else r_fcnt <= r_fcnt + 1'b1;
        DONE: r_state <= DONE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Data and tags carry no reset; valid bits guard them.
  always_ff @(posedge CLK) begin
    if (r_state == FETCH && w_xfer) begin
      r_data[r_way][r_idx][r_word] <= dload;
      if (w_last) r_tag[r_way][r_idx] <= r_rtag;
    end
    if (dhit && dmemWEN) r_data[w_hway][w_idx][w_boff] <= dmemstore;
  end
endmodule

// File: doc/dcache_assoc.md
DCACHE_ASSOC -- requirements
Module: dcache_assoc

Interface
REQ-001 Parameter WAYS, default 2, associativity; power of two, 1..8.
REQ-002 Parameter SETS, default 8, sets per way; power of two, 2..64.
REQ-003 Parameter BLK_WORDS, default 2, 32-bit words per block; power of two, 1..8.
REQ-004 CLK  in  1  sole clock; all state updates on rising edge.
REQ-005 nRST  in  1  reset, asynchronous, active-low.
REQ-006 dmemREN  in  1  datapath read request.
REQ-007 dmemWEN  in  1  datapath write request; never asserted together with dmemREN.
REQ-008 dmemaddr  in  32  byte address, word aligned.
REQ-009 dmemstore  in  32  write data.
REQ-010 halt  in  1  request flush of all dirty blocks.
REQ-011 dhit  out  1  request satisfied this cycle.
REQ-012 dmemload  out  32  read data, valid when dhit=1.
REQ-013 flushed  out  1  flush complete; sticky until reset.
REQ-014 dREN  out  1  memory read strobe.
REQ-015 dWEN  out  1  memory write strobe.
REQ-016 daddr  out  32  memory word address, bits[1:0]=0.
REQ-017 dstore  out  32  memory write data.
REQ-018 dload  in  32  memory read data, valid when dwait=0.
REQ-019 dwait  in  1  memory busy; a word transfer completes on an edge where strobe=1 and dwait=0.

Function
REQ-020 Address split, LSB first: byte offset 2 bits, block offset log2(BLK_WORDS) bits, index log2(SETS) bits, tag = remaining bits.
REQ-021 Each frame holds valid, dirty, tag and BLK_WORDS data words; each set holds one log2(WAYS)-bit LRU age per way.
REQ-022 States: IDLE, WB, FETCH, FLUSH, DONE.
REQ-023 IDLE, request, tag match in a valid way: dhit=1 combinationally in the same cycle; read returns the addressed word; write updates the word and sets dirty at the edge.
REQ-024 On every hit, the accessed way's age becomes 0; ways with age below its old age increment by 1; others hold.
REQ-025 IDLE miss: victim is the lowest-numbered invalid way, else the way with age WAYS-1; next state WB if victim valid and dirty, else FETCH.
REQ-026 WB: words 0..BLK_WORDS-1 in order; dWEN=1, daddr={victim tag, index, word, 2'b00}, dstore=victim word; word counter advances on completion; after the last word go to FETCH.
REQ-027 FETCH: dREN=1, daddr={request tag, index, word, 2'b00}; dload written into the victim on each completion; after the last word set valid=1, dirty=0, tag=request tag, and go to IDLE.
REQ-028 A request is re-evaluated in IDLE after a fill and hits there; dhit=0 in all states other than IDLE.
REQ-029 halt in IDLE has priority over any request and causes entry to FLUSH with the set/way counter at 0.
REQ-030 FLUSH: scan set-major, way-minor; each valid dirty frame is written back as in REQ-026, then its dirty bit is cleared; clean frames take 1 cycle each; after the last frame go to DONE.
REQ-031 DONE: flushed=1, no memory strobes, requests ignored, dhit=0; the state is held until reset.
REQ-032 dREN and dWEN are never both 1; strobes and daddr are held stable while dwait=1.
REQ-033 Counters do not wrap: the word counter resets to 0 on every WB/FETCH entry; the flush counter stops at SETS*WAYS-1.

Reset
REQ-034 nRST low: state=IDLE, all valid/dirty=0, age of way w = w, counters=0, flushed=0, dREN=dWEN=0, daddr=dstore=dmemload=0, dhit=0; applied immediately, also mid-transfer.
REQ-035 Data and tag arrays need not be cleared by reset.
REQ-036 The first edge after nRST rises operates normally from IDLE.

Verification
REQ-037 Defaults, dwait=0: read 0x100 miss -> FETCH of 0x100 and 0x104 (2 cycles), then dhit=1 with dmemload=mem[0x100].
REQ-038 Write 0xDEADBEEF to 0x100 (hit), then reads of 0x140 and 0x180 (same set 0, WAYS=2) -> the 0x180 miss writes back 0x100/0x104 with dstore=0xDEADBEEF first, then fetches 0x180.
REQ-039 LRU: read 0x100, 0x140, 0x100, then 0x180 -> way holding 0x140 is evicted; a subsequent read of 0x100 hits without strobes.
REQ-040 dwait held high 5 cycles during FETCH -> daddr/dREN stable, no dhit until the fill completes.
REQ-041 Dirty blocks in sets 0 and 7, then halt -> exactly 4 memory writes in set order, then flushed=1 held; later requests get dhit=0.
REQ-042 nRST pulsed low mid-WB -> all outputs 0 immediately; a re-read of the prior hit address misses.
